// File: rtl/ex_alu_retire.sv
// ex_alu_retire: registered retire stage of the Raisin64 integer ALU.
// Captures stage-1 results with their destination index into a 2-entry skid
// buffer (head + skid) under valid/ready, presents the head to writeback, and
// optionally exposes both held entries to the operand-forwarding network.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           stage-1 handshake (in_ready is a flop)
//   in_result, in_rd            stage-1 result and destination index
//   flush                       drop every held result
//   out_valid/out_ready         writeback handshake on the head entry
//   out_result, out_rd, out_wen head payload; out_wen masks r0 writes
//   byp0_*                      head entry forward
//   byp1_*                      skid (younger) entry forward
//
// Configuration macro: EX_ALU_RETIRE_BYPASS_EN
//   defined   -> byp ports mirror the held entries (valid suppressed for r0)
//   undefined -> byp ports tied to 0
module ex_alu_retire #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wen,
  output logic              byp0_valid,
  output logic [REG_W-1:0]  byp0_rd,
  output logic [DATA_W-1:0] byp0_data,
  output logic              byp1_valid,
  output logic [REG_W-1:0]  byp1_rd,
  output logic [DATA_W-1:0] byp1_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_head_valid;
  logic [DATA_W-1:0]   r_head_data;
  logic [REG_W-1:0]    r_head_rd;
  logic                r_skid_valid;
  logic [DATA_W-1:0]   r_skid_data;
  logic [REG_W-1:0]    r_skid_rd;

  logic                w_accept;
  logic                w_drain;

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_head_valid && out_ready;

  // Occupancy FSM; ready and valid bits are flops updated with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_in_ready   <= 1'b1;
      r_head_valid <= 1'b0;
      r_head_data  <= DATA_W'(0);
      r_head_rd    <= REG_W'(0);
      r_skid_valid <= 1'b0;
      r_skid_data  <= DATA_W'(0);
      r_skid_rd    <= REG_W'(0);
    end else if (flush) begin
      // A same-cycle drain already left; a same-cycle accept is dropped.
      r_state      <= S_EMPTY;
      r_in_ready   <= 1'b1;
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state      <= S_ONE;
            r_head_valid <= 1'b1;
            r_head_data  <= in_result;
            r_head_rd    <= in_rd;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_head_data <= in_result;
            r_head_rd   <= in_rd;
          end else if (w_accept) begin
            r_state      <= S_FULL;
            r_in_ready   <= 1'b0;
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_result;
            r_skid_rd    <= in_rd;
          end else if (w_drain) begin
            r_state      <= S_EMPTY;
            r_head_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            r_state      <= S_ONE;
            r_in_ready   <= 1'b1;
            r_skid_valid <= 1'b0;
            r_head_data  <= r_skid_data;
            r_head_rd    <= r_skid_rd;
          end
        end
        default: begin
          r_state      <= S_EMPTY;
          r_in_ready   <= 1'b1;
          r_head_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_head_valid;
  assign out_result = r_head_data;
  assign out_rd     = r_head_rd;
  assign out_wen    = r_head_valid && (r_head_rd != REG_W'(0));

  // Forwarding taps read only stored state, never the inputs.
`ifdef EX_ALU_RETIRE_BYPASS_EN
  assign byp0_valid = r_head_valid && (r_head_rd != REG_W'(0));
  assign byp0_rd    = r_head_rd;
  assign byp0_data  = r_head_data;
  assign byp1_valid = r_skid_valid && (r_skid_rd != REG_W'(0));
  assign byp1_rd    = r_skid_rd;
  assign byp1_data  = r_skid_data;
`else
  assign byp0_valid = 1'b0;
  assign byp0_rd    = REG_W'(0);
  assign byp0_data  = DATA_W'(0);
  assign byp1_valid = 1'b0;
  assign byp1_rd    = REG_W'(0);
  assign byp1_data  = DATA_W'(0);
`endif

endmodule

// File: tb/tb_ex_alu_retire.sv
module tb_ex_alu_retire;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 6;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [REG_W-1:0]  in_rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_wen;
  logic              byp0_valid;
  logic [REG_W-1:0]  byp0_rd;
  logic [DATA_W-1:0] byp0_data;
  logic              byp1_valid;
  logic [REG_W-1:0]  byp1_rd;
  logic [DATA_W-1:0] byp1_data;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO of held results, capacity 2, oldest at index 0.
  ent_t q[$];

`ifdef EX_ALU_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ex_alu_retire #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen),
    .byp0_valid(byp0_valid), .byp0_rd(byp0_rd), .byp0_data(byp0_data),
    .byp1_valid(byp1_valid), .byp1_rd(byp1_rd), .byp1_data(byp1_data)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit.
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d,
                             input logic [REG_W-1:0] rd, input logic ordy,
                             input logic fl);
    bit acc, drn;
    ent_t e;
    in_valid  = v;
    in_result = d;
    in_rd     = rd;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.rd = rd;
        e.d  = d;
        q.push_back(e);
      end
    end
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 0; in_result = '0; in_rd = '0; flush = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL reset_out_wen got=%b exp=0", out_wen); end
    total++; if (out_result !== '0 || out_rd !== '0) begin bad++; $display("FAIL reset_out_data got=%h/%0d exp=0/0", out_result, out_rd); end
    total++; if ({byp0_valid, byp0_rd, byp0_data, byp1_valid, byp1_rd, byp1_data} !== '0) begin
      bad++; $display("FAIL reset_bypass got=%b/%0d/%h %b/%0d/%h exp=all 0", byp0_valid, byp0_rd, byp0_data, byp1_valid, byp1_rd, byp1_data);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, DATA_W'(i * 16), REG_W'(i), 1'b1, 1'b0);
      total++; if (out_valid !== 1'b1 || out_result !== DATA_W'(i * 16) || out_rd !== REG_W'(i)) begin
        bad++; $display("FAIL stream_%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_result, out_rd, DATA_W'(i * 16), i);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    drive_cycle(1'b1, 64'hA, 6'd3, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_one_ready got=%b exp=1", in_ready); end
    drive_cycle(1'b1, 64'hB, 6'd4, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_result !== 64'hA || out_rd !== 6'd3) begin
      bad++; $display("FAIL bp_head got=%b/%h/%0d exp=1/a/3", out_valid, out_result, out_rd);
    end
    // Offered input while FULL must be refused.
    drive_cycle(1'b1, 64'hC, 6'd7, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0 || out_result !== 64'hA) begin bad++; $display("FAIL bp_hold got=%b/%h exp=0/a", in_ready, out_result); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_result !== 64'hB || out_rd !== 6'd4 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_drain1 got=%b/%h/%0d rdy=%b exp=1/b/4 rdy=1", out_valid, out_result, out_rd, in_ready);
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain2 got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_reg;
    drive_cycle(1'b1, 64'hFFFF, 6'd0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_result !== 64'hFFFF) begin bad++; $display("FAIL zero_valid got=%b/%h exp=1/ffff", out_valid, out_result); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL zero_wen got=%b exp=0", out_wen); end
    total++; if (byp0_valid !== 1'b0) begin bad++; $display("FAIL zero_byp0 got=%b exp=0", byp0_valid); end
    drive_cycle(1'b1, 64'h1234, 6'd9, 1'b1, 1'b0);
    total++; if (out_wen !== 1'b1 || out_rd !== 6'd9) begin bad++; $display("FAIL zero_next_wen got=%b/%0d exp=1/9", out_wen, out_rd); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_bypass;
    drive_cycle(1'b1, 64'h55, 6'd5, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h66, 6'd6, 1'b0, 1'b0);
    if (BYP) begin
      total++; if (byp0_valid !== 1'b1 || byp0_rd !== 6'd5 || byp0_data !== 64'h55) begin
        bad++; $display("FAIL byp0 got=%b/%0d/%h exp=1/5/55", byp0_valid, byp0_rd, byp0_data);
      end
      total++; if (byp1_valid !== 1'b1 || byp1_rd !== 6'd6 || byp1_data !== 64'h66) begin
        bad++; $display("FAIL byp1 got=%b/%0d/%h exp=1/6/66", byp1_valid, byp1_rd, byp1_data);
      end
    end else begin
      total++; if ({byp0_valid, byp0_rd, byp0_data, byp1_valid, byp1_rd, byp1_data} !== '0) begin
        bad++; $display("FAIL byp_tied got=%b/%0d/%h %b/%0d/%h exp=all 0", byp0_valid, byp0_rd, byp0_data, byp1_valid, byp1_rd, byp1_data);
      end
    end
  endtask

  // Starts FULL (left by test_bypass): flush with an offered input.
  task automatic test_flush;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
    drive_cycle(1'b1, 64'hDEAD, 6'd11, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b rdy=%b exp=0 rdy=1", out_valid, in_ready); end
    total++; if (byp0_valid !== 1'b0 || byp1_valid !== 1'b0) begin bad++; $display("FAIL flush_byp got=%b%b exp=00", byp0_valid, byp1_valid); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_reappear got=%b exp=0", out_valid); end
    // ONE state, accept + flush: the accepted value must be discarded.
    drive_cycle(1'b1, 64'h77, 6'd2, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h88, 6'd3, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_one got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset;
    drive_cycle(1'b1, 64'h99, 6'd8, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ares_pre got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wen !== 1'b0) begin
      bad++; $display("FAIL ares_now got=v%b r%b w%b exp=v0 r1 w0", out_valid, in_ready, out_wen);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b1, 64'hAB, 6'd12, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_result !== 64'hAB) begin bad++; $display("FAIL ares_after got=%b/%h exp=1/ab", out_valid, out_result); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic v, o, f;
    logic [DATA_W-1:0] d;
    logic [REG_W-1:0] rd;
    logic ev, e0, e1;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      o  = ($urandom_range(0, 2) != 0);
      f  = ($urandom_range(0, 31) == 0);
      d  = {$urandom, $urandom};
      rd = REG_W'($urandom_range(0, 63));
      drive_cycle(v, d, rd, o, f);
      ev = (q.size() > 0);
      e0 = BYP && (q.size() > 0) && (q[0].rd != '0);
      e1 = BYP && (q.size() > 1) && (q[1].rd != '0);
      total++; if (out_valid !== ev || in_ready !== (q.size() < 2)) begin
        bad++; $display("FAIL rnd_%0d_hs got=v%b r%b exp=v%b r%b", n, out_valid, in_ready, ev, q.size() < 2);
      end
      if (ev) begin
        total++; if (out_result !== q[0].d || out_rd !== q[0].rd || out_wen !== (q[0].rd != '0)) begin
          bad++; $display("FAIL rnd_%0d_head got=%h/%0d/%b exp=%h/%0d/%b", n, out_result, out_rd, out_wen, q[0].d, q[0].rd, q[0].rd != '0);
        end
      end else begin
        total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL rnd_%0d_wen got=%b exp=0", n, out_wen); end
      end
      total++; if (byp0_valid !== e0 || byp1_valid !== e1) begin
        bad++; $display("FAIL rnd_%0d_bypv got=%b%b exp=%b%b", n, byp0_valid, byp1_valid, e0, e1);
      end
      if (e0) begin
        total++; if (byp0_rd !== q[0].rd || byp0_data !== q[0].d) begin bad++; $display("FAIL rnd_%0d_byp0 got=%0d/%h exp=%0d/%h", n, byp0_rd, byp0_data, q[0].rd, q[0].d); end
      end
      if (e1) begin
        total++; if (byp1_rd !== q[1].rd || byp1_data !== q[1].d) begin bad++; $display("FAIL rnd_%0d_byp1 got=%0d/%h exp=%0d/%h", n, byp1_rd, byp1_data, q[1].rd, q[1].d); end
      end
      if (!BYP) begin
        total++; if ({byp0_rd, byp0_data, byp1_rd, byp1_data} !== '0) begin bad++; $display("FAIL rnd_%0d_bypd got nonzero exp=0", n); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_zero_reg();
    test_bypass();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
